// File: rtl/rx_pkg.sv
// rx_pkg: shared flit width default and receive FSM states for the serial link receiver.
package rx_pkg;
  localparam int DEF_SIZE = 8;
  typedef enum logic {IDLE, RECV} rx_state_e;
endpackage

// File: rtl/rx_fifo.sv
// rx_fifo: DEPTH-entry flit buffer; a simultaneous pop frees the slot for a push even when full.
module rx_fifo #(
  parameter int SIZE = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            push,
  input  logic [SIZE-1:0] push_data,
  input  logic            pop,
  output logic [SIZE-1:0] head,
  output logic [CW-1:0]   count,
  output logic            full,
  output logic            empty,
  output logic            drop
);
  logic [SIZE-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop = push && !do_push;
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rx.sv
// rx: serial link receiver; deserialises start-bit framed flits, LSB first, into a small FIFO.
module rx
  import rx_pkg::*;
#(
  parameter int SIZE = DEF_SIZE,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            serial_in,
  output logic            channel_busy,
  output logic [SIZE-1:0] data_out,
  output logic            data_valid,
  input  logic            data_ack,
  output logic            rx_active,
  output logic            overflow
);
  localparam int BW = SIZE > 1 ? $clog2(SIZE) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  rx_state_e state, state_nx;
  logic [BW-1:0] bit_cnt;
  logic [SIZE-1:0] shreg, shreg_nx;
  logic [CW-1:0] count;
  logic push, last, full, empty, drop;
  assign shreg_nx = {serial_in, shreg[SIZE-1:1]};
  assign last = bit_cnt == BW'(SIZE - 1);
  assign rx_active = state == RECV;
  assign data_valid = !empty;
  // A frame in flight already owns a slot, so count + rx_active >= DEPTH reduces to this.
  assign channel_busy = full || (rx_active && count == CW'(DEPTH - 1));
  always_comb begin
    state_nx = state;
    push = 1'b0;
    if (state == IDLE) state_nx = serial_in ? RECV : IDLE;
    else begin
      push = last;
      state_nx = last ? IDLE : RECV;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      bit_cnt <= '0;
      shreg <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      overflow <= overflow || drop;
      if (state == IDLE) bit_cnt <= '0;
      else begin
        shreg <= shreg_nx;
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end
  rx_fifo #(.SIZE(SIZE), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset_n(reset_n),
    .push(push),
    .push_data(shreg_nx),
    .pop(data_ack),
    .head(data_out),
    .count(count),
    .full(full),
    .empty(empty),
    .drop(drop)
  );
endmodule

// File: tb/tb_rx.sv
// tb_rx: scoreboard bench for rx with SIZE=8, DEPTH=2; expected flits queue up as frames are sent.
module tb_rx;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic serial_in = 1'b0;
  logic data_ack = 1'b0;
  logic channel_busy, data_valid, rx_active, overflow;
  logic [7:0] data_out;
  logic [7:0] q[$];
  int n_cmp = 0;
  int n_bad = 0;
  rx #(.SIZE(8), .DEPTH(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .serial_in(serial_in),
    .channel_busy(channel_busy),
    .data_out(data_out),
    .data_valid(data_valid),
    .data_ack(data_ack),
    .rx_active(rx_active),
    .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic head_chk(input string tag);
    if (q.size() == 0) chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    else chk(tag, data_out, q.pop_front());
  endtask
  // Frame starts on the next negedge; returns on the negedge after the last data bit was sampled.
  task automatic send(input logic [7:0] b, input bit keep, input bit ack_last);
    if (keep) q.push_back(b);
    @(negedge clk) serial_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk) serial_in = b[i];
      if (i == 7 && ack_last) begin
        head_chk("ack_same_edge_head");
        data_ack = 1'b1;
      end
    end
    @(negedge clk) serial_in = 1'b0;
    data_ack = 1'b0;
  endtask
  task automatic pop(input string tag);
    chk({tag, "_valid"}, data_valid, 1'b1);
    head_chk(tag);
    data_ack = 1'b1;
    @(negedge clk) data_ack = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_busy", channel_busy, 1'b0);
    chk("rst_active", rx_active, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_data", data_out, 8'h00);
    reset_n = 1'b1;
    @(negedge clk);
    send(8'hA5, 1'b1, 1'b0);
    chk("t1_valid", data_valid, 1'b1);
    chk("t1_active", rx_active, 1'b0);
    pop("t1_a5");
    chk("t1_empty", data_valid, 1'b0);
    send(8'h00, 1'b1, 1'b0);
    send(8'hFF, 1'b1, 1'b0);
    pop("t2_00");
    pop("t2_ff");
    chk("t2_empty", data_valid, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    chk("t3_busy_one", channel_busy, 1'b0);
    q.push_back(8'hC3);
    @(negedge clk) serial_in = 1'b1;
    @(negedge clk);
    chk("t3_busy_start", channel_busy, 1'b1);
    for (int i = 0; i < 8; i++) begin
      serial_in = (8'hC3 >> i) & 1;
      @(negedge clk);
    end
    serial_in = 1'b0;
    chk("t3_busy_full", channel_busy, 1'b1);
    pop("t3_5a");
    chk("t3_busy_after_ack", channel_busy, 1'b0);
    send(8'h96, 1'b1, 1'b1);
    chk("t4_valid", data_valid, 1'b1);
    chk("t4_busy", channel_busy, 1'b0);
    pop("t4_96");
    chk("t4_empty", data_valid, 1'b0);
    send(8'h11, 1'b1, 1'b0);
    send(8'h22, 1'b1, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    chk("t5_ovf", overflow, 1'b1);
    chk("t5_head", data_out, q[0]);
    chk("t5_busy", channel_busy, 1'b1);
    pop("t5_11");
    pop("t5_22");
    chk("t5_no_dropped", data_valid, 1'b0);
    chk("t5_ovf_sticky", overflow, 1'b1);
    send(8'h77, 1'b1, 1'b0);
    @(negedge clk) serial_in = 1'b1;
    for (int i = 0; i < 4; i++) @(negedge clk) serial_in = i[0];
    chk("t6_pre_busy", channel_busy, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", data_valid, 1'b0);
    chk("t6_rst_busy", channel_busy, 1'b0);
    chk("t6_rst_active", rx_active, 1'b0);
    chk("t6_rst_ovf", overflow, 1'b0);
    chk("t6_rst_data", data_out, 8'h00);
    q.delete();
    @(negedge clk) serial_in = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    @(negedge clk);
    chk("t6_idle_valid", data_valid, 1'b0);
    send(8'h3C, 1'b1, 1'b0);
    pop("t6_3c");
    chk("t6_empty", data_valid, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
